// File: rtl/uvme_clk_st_freq_chkr.sv
// Monitored-clock period checker: syncs mon_clk, measures periods in clk cycles.
// Optional high-phase measurement when UVME_CLK_ST_FREQ_CHKR_DUTY_EN is defined.
module uvme_clk_st_freq_chkr #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] timeout,
  input  logic             mon_clk,
  output logic             period_vld,
  output logic [CNT_W-1:0] period,
  output logic             period_err,
  output logic             stuck_err,
  output logic [31:0]      edge_cnt,
  output logic [CNT_W-1:0] high_time
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    STUCK
  } state_e;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_X = (CNT_W+1)'(TOL);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       period_q;
  logic                   vld_q;
  logic                   err_q;
  logic                   stuck_q;
  logic [31:0]            edge_q;
  logic [31:0]            edge_d;

  logic             synced;
  logic             rise;
  logic             tmo;
  logic             err_d;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   exp_x;
  logic [CNT_W:0]   diff;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~hist_q;
  assign tmo    = (timeout != '0) && (cnt_q >= timeout);
  assign cnt_d  = (&cnt_q) ? cnt_q : cnt_q + ONE;
  assign edge_d = (&edge_q) ? edge_q : edge_q + 32'd1;

  // Deviation is taken one bit wider so it never wraps.
  assign cnt_x = {1'b0, cnt_q};
  assign exp_x = {1'b0, exp_period};
  assign diff  = (cnt_x >= exp_x) ? cnt_x - exp_x : exp_x - cnt_x;
  assign err_d = diff > TOL_X;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
      edge_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      hist_q  <= synced;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      stuck_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= ARM;
            cnt_q   <= '0;
            edge_q  <= '0;
          end
          ARM: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= ONE;
              edge_q  <= edge_d;
            end else if (tmo) begin
              state_q <= STUCK;
              stuck_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q <= cnt_q;
              vld_q    <= 1'b1;
              err_q    <= err_d;
              cnt_q    <= ONE;
              edge_q   <= edge_d;
            end else if (tmo) begin
              state_q <= STUCK;
              stuck_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          STUCK: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= ONE;
              edge_q  <= edge_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period_vld = vld_q;
  assign period     = period_q;
  assign period_err = err_q;
  assign stuck_err  = stuck_q;
  assign edge_cnt   = edge_q;

`ifdef UVME_CLK_ST_FREQ_CHKR_DUTY_EN
  logic             restart;
  logic             report;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] high_q;

  assign restart = enable && (state_q != IDLE) && rise;
  assign report  = enable && (state_q == MEASURE) && rise;

  // The rise cycle itself is the first high cycle, hence restart at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      if (report) high_q <= hcnt_q;
      if (restart) begin
        hcnt_q <= ONE;
      end else if (enable && (state_q == MEASURE) && synced && !(&hcnt_q)) begin
        hcnt_q <= hcnt_q + ONE;
      end
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

endmodule

// File: doc/uvme_clk_st_freq_chkr.md
# uvme_clk_st_freq_chkr

Synthesizable clock-frequency checker that sits directly downstream of the clock agent's passive interface in the clock self-test environment. It samples the monitored clock as data in the bench reference clock domain and measures each monitored period in reference cycles. It compares each period against a programmed expectation with tolerance and flags a stopped clock. Results feed the self-test assertion checker and scoreboard.

## Interface
Parameters:
- `CNT_W`, 16: width of the period, timeout and duty counters.
- `SYNC_STAGES`, 2: flops in the `mon_clk` synchronizer; legal values are 2 or more.
- `TOL`, 1: allowed absolute period deviation, in reference cycles.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: reference clock; all logic is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: checker run control.
- `exp_period` in CNT_W: expected period in `clk` cycles; sampled on every report.
- `timeout` in CNT_W: stuck threshold in `clk` cycles; 0 disables stuck detection.
- `mon_clk` in 1: monitored clock, treated as asynchronous data.
- `period_vld` out 1: one-cycle pulse when a new period is reported.
- `period` out CNT_W: last measured period.
- `period_err` out 1: pulse together with `period_vld` when the period is out of tolerance.
- `stuck_err` out 1: one-cycle pulse on entry to STUCK.
- `edge_cnt` out 32: count of detected rising edges; saturates.
- `high_time` out CNT_W: high-phase length of the last period, in `clk` cycles.

## Operation
- Synchronizer: `mon_clk` passes through `SYNC_STAGES` flops, then one history flop. `rise` = synced AND NOT history.
- `cnt` counts `clk` cycles and saturates at all-ones.
- State machine:
  - IDLE: entered from reset or whenever `enable` = 0, in any state. `cnt` = 0. Outputs hold their values except the pulses, which are 0.
  - IDLE → ARM when `enable` = 1. Entering ARM clears `edge_cnt` and starts `cnt` at 0.
  - ARM: `cnt` increments every cycle.
    - On `rise`: go to MEASURE, set `cnt` to 1, increment `edge_cnt`. No report is made.
    - If `timeout` != 0 and `cnt` >= `timeout`: go to STUCK.
  - MEASURE: `cnt` increments every cycle.
    - On `rise`: set `period` to `cnt`, pulse `period_vld`, set `cnt` to 1, increment `edge_cnt`.
    - `period_err` = |`cnt` − `exp_period`| > `TOL`. The difference is computed at CNT_W+1 bits with no wrap.
    - If `timeout` != 0 and `cnt` >= `timeout` with no `rise` that cycle: go to STUCK and pulse `stuck_err`.
  - STUCK: `cnt` is held. On `rise`: go to MEASURE, set `cnt` to 1, increment `edge_cnt`. No period is reported for the stalled interval.
- Priority within one cycle: `enable` = 0, then `rise`, then timeout.
- A saturated `cnt` is reported as all-ones. It compares as a normal value.
- `edge_cnt` stops at 0xFFFF_FFFF.

## Timing
- Reset values: state IDLE, all outputs 0, synchronizer and history flops 0.
- Detection latency: a `mon_clk` rising edge makes `rise` true `SYNC_STAGES` + 1 `clk` edges later, with ±1 cycle synchronizer uncertainty.
- `period`, `period_vld` and `period_err` are registered and appear one cycle after `rise`.
- `stuck_err` is registered and appears one cycle after the timeout condition.
- Monitored clocks with a high or low phase shorter than 2 `clk` cycles are out of scope and produce no defined results.
- Deasserting `enable` mid-period discards the partial measurement. Reasserting it requires a fresh ARM edge.

## Configuration
- Macro: `UVME_CLK_ST_FREQ_CHKR_DUTY_EN`.
- Defined: a high-phase counter clears on `rise` and increments each cycle the synced clock is 1 in MEASURE. On each report, `high_time` loads the count.
- Undefined: the counter is not built and `high_time` is tied to 0.

## Test plan
- `exp_period` = 10, `TOL` = 1, `mon_clk` toggling every 5 `clk` → after the arm edge, `period_vld` pulses every 10 cycles with `period` = 10 and `period_err` = 0. `high_time` = 5 when DUTY_EN is defined.
- `exp_period` = 10, `TOL` = 1, `mon_clk` period 12 → `period` = 12 and `period_err` pulses on every report. With period 11, `period_err` = 0.
- `timeout` = 40, `mon_clk` stopped after 3 edges → exactly one `stuck_err`, asserted 41 cycles after the last `rise`. On the restarted clock, the first report comes one full period after the recovery edge; `edge_cnt` = 4 at the recovery edge.
- `enable` dropped for 5 cycles mid-period, then restored → no report for the broken period, `edge_cnt` cleared to 0, and the ARM edge is not reported.
- `reset` asserted mid-MEASURE → all outputs read 0 asynchronously and the state is IDLE. After release, measurement resumes only through ARM.
- `CNT_W` = 4, `timeout` = 0, `mon_clk` period 20 → `period` = 15 (saturated) and `period_err` = 1 against `exp_period` = 10.
